// File: rtl/crosshair_ctl_if.sv
// vga_if: pixel timing bundle (counters, sync, blanking) plus 12-bit RGB.
// The "in" modport is for a block consuming the stream, "out" for a block producing it.
interface vga_if;
  logic [11:0] hcount;
  logic [11:0] vcount;
  logic        hsync;
  logic        vsync;
  logic        hblnk;
  logic        vblnk;
  logic [11:0] rgb;

  modport in  (input  hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
  modport out (output hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
endinterface

// File: rtl/crosshair_ctl.sv
// crosshair_ctl: overlays a plus-shaped crosshair on a VGA pixel stream with
// one clock of latency. The cursor position is sampled once per frame, and a
// shot request flashes the crosshair for FLASH_FRAMES frames followed by a
// COOL_FRAMES lockout.
// Optional feature: define CROSSHAIR_CENTER_DOT_EN to paint the centre pixel
// white outside blanking, independent of the flash state.
module crosshair_ctl #(
  parameter int          SIZE         = 15,
  parameter int          THICK        = 3,
  parameter logic [11:0] COLOR_IDLE   = 12'hF00,
  parameter logic [11:0] COLOR_SHOT   = 12'hFF0,
  parameter int          FLASH_FRAMES = 8,
  parameter int          COOL_FRAMES  = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [11:0] xpos,
  input  logic [11:0] ypos,
  input  logic        shot,
  vga_if.in           in,
  vga_if.out          out,
  output logic        shot_ack,
  output logic        busy
);

  localparam logic signed [12:0] HALF_SPAN  = 13'(SIZE / 2);
  localparam logic signed [12:0] HALF_THICK = 13'(THICK / 2);
  localparam logic [7:0]         FLASH_LD   = 8'(FLASH_FRAMES);
  localparam logic [7:0]         COOL_LD    = 8'(COOL_FRAMES);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FLASH = 2'd1,
    ST_COOL  = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        ack_q, ack_d;
  logic        busy_q, busy_d;
  logic        vblnk_prev_q;
  logic [11:0] cx_q, cx_d;
  logic [11:0] cy_q, cy_d;

  logic [11:0] hcount_q, vcount_q, rgb_q, rgb_d;
  logic        hsync_q, vsync_q, hblnk_q, vblnk_q;

  logic               frame_start;
  logic               blank;
  logic signed [12:0] dx, dy, adx, ady;
  logic               hit;

  assign frame_start = in.vblnk & ~vblnk_prev_q;
  assign blank       = in.hblnk | in.vblnk;

  // Cursor position is only sampled at frame start so a frame is never torn.
  always_comb begin
    cx_d = cx_q;
    cy_d = cy_q;
    if (frame_start) begin
      cx_d = xpos;
      cy_d = ypos;
    end
  end

  // Distance from the centre in signed arithmetic so arms clip at 0 instead of wrapping.
  always_comb begin
    dx  = $signed({1'b0, in.hcount}) - $signed({1'b0, cx_q});
    dy  = $signed({1'b0, in.vcount}) - $signed({1'b0, cy_q});
    adx = (dx < 0) ? -dx : dx;
    ady = (dy < 0) ? -dy : dy;
    hit = ((adx <= HALF_SPAN) && (ady <= HALF_THICK)) ||
          ((ady <= HALF_SPAN) && (adx <= HALF_THICK));
  end

  // Pixel colour selection: blanking passes through, crosshair pixels get the state colour.
  always_comb begin
    rgb_d = in.rgb;
    if (!blank && hit) begin
      rgb_d = (state_q == ST_FLASH) ? COLOR_SHOT : COLOR_IDLE;
    end
`ifdef CROSSHAIR_CENTER_DOT_EN
    if (!blank && (adx == 13'sd0) && (ady == 13'sd0)) begin
      rgb_d = 12'hFFF;
    end
`endif
  end

  // Shot FSM: counts frame starts through flash and cooldown; shots outside IDLE are dropped.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ack_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (shot) begin
          // A shot on a frame-start cycle still gets the full count.
          state_d = ST_FLASH;
          cnt_d   = FLASH_LD;
          ack_d   = 1'b1;
        end
      end
      ST_FLASH: begin
        if (frame_start) begin
          if (cnt_q == 8'd1) begin
            if (COOL_LD == 8'd0) begin
              state_d = ST_IDLE;
              cnt_d   = 8'd0;
            end else begin
              state_d = ST_COOL;
              cnt_d   = COOL_LD;
            end
          end else begin
            cnt_d = cnt_q - 8'd1;
          end
        end
      end
      ST_COOL: begin
        if (frame_start) begin
          if (cnt_q == 8'd1) begin
            state_d = ST_IDLE;
            cnt_d   = 8'd0;
          end else begin
            cnt_d = cnt_q - 8'd1;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = 8'd0;
      end
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  // Control state, cursor latch and frame-edge detector.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      cnt_q        <= 8'd0;
      ack_q        <= 1'b0;
      busy_q       <= 1'b0;
      vblnk_prev_q <= 1'b0;
      cx_q         <= 12'd0;
      cy_q         <= 12'd0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      ack_q        <= ack_d;
      busy_q       <= busy_d;
      vblnk_prev_q <= in.vblnk;
      cx_q         <= cx_d;
      cy_q         <= cy_d;
    end
  end

  // One-cycle pipeline stage for timing fields and the mixed colour.
  always_ff @(posedge clk) begin
    if (rst) begin
      hcount_q <= 12'd0;
      vcount_q <= 12'd0;
      hsync_q  <= 1'b0;
      vsync_q  <= 1'b0;
      hblnk_q  <= 1'b0;
      vblnk_q  <= 1'b0;
      rgb_q    <= 12'd0;
    end else begin
      hcount_q <= in.hcount;
      vcount_q <= in.vcount;
      hsync_q  <= in.hsync;
      vsync_q  <= in.vsync;
      hblnk_q  <= in.hblnk;
      vblnk_q  <= in.vblnk;
      rgb_q    <= rgb_d;
    end
  end

  assign out.hcount = hcount_q;
  assign out.vcount = vcount_q;
  assign out.hsync  = hsync_q;
  assign out.vsync  = vsync_q;
  assign out.hblnk  = hblnk_q;
  assign out.vblnk  = vblnk_q;
  assign out.rgb    = rgb_q;
  assign shot_ack   = ack_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_crosshair_ctl.sv
// Bench for crosshair_ctl with default parameters. Pixels are presented
// sparsely (a one-cycle vblank marks each frame start, then only a window
// around the cursor is scanned) to keep frames short.
module tb_crosshair_ctl;

  logic        clk = 1'b0;
  logic        rst;
  logic [11:0] xpos, ypos;
  logic        shot;
  logic        shot_ack, busy;

  vga_if vin ();
  vga_if vout ();

  crosshair_ctl dut (
    .clk      (clk),
    .rst      (rst),
    .xpos     (xpos),
    .ypos     (ypos),
    .shot     (shot),
    .in       (vin),
    .out      (vout),
    .shot_ack (shot_ack),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference state: position drawn this frame and the expected look of the frame.
  int model_cx = 0;
  int model_cy = 0;
  bit exp_flash = 0;
  bit exp_busy  = 0;

  function automatic logic [11:0] exp_rgb(input int h, input int v, input bit hb,
                                          input bit vb, input logic [11:0] rgb);
    int adx, ady;
    if (hb || vb) return rgb;
    adx = (h > model_cx) ? h - model_cx : model_cx - h;
    ady = (v > model_cy) ? v - model_cy : model_cy - v;
`ifdef CROSSHAIR_CENTER_DOT_EN
    if (adx == 0 && ady == 0) return 12'hFFF;
`endif
    if ((adx <= 7 && ady <= 1) || (ady <= 7 && adx <= 1))
      return exp_flash ? 12'hFF0 : 12'hF00;
    return rgb;
  endfunction

  // Present one pixel for one clock and check what appears one cycle later.
  task automatic pixel(input int h, input int v, input bit hb, input bit vb,
                       input bit do_shot, input bit exp_ack);
    logic [11:0] rgb, er;
    logic        hs, vs;
    logic [27:0] et, ot;
    rgb = 12'($urandom);
    hs  = 1'($urandom_range(0, 1));
    vs  = 1'($urandom_range(0, 1));
    vin.hcount = 12'(h);
    vin.vcount = 12'(v);
    vin.hsync  = hs;
    vin.vsync  = vs;
    vin.hblnk  = hb;
    vin.vblnk  = vb;
    vin.rgb    = rgb;
    shot       = do_shot;
    er = exp_rgb(h, v, hb, vb, rgb);
    et = {12'(h), 12'(v), hs, vs, hb, vb};
    @(posedge clk);
    #1;
    shot = 1'b0;
    ot = {vout.hcount, vout.vcount, vout.hsync, vout.vsync, vout.hblnk, vout.vblnk};
    checks++;
    if (vout.rgb !== er) begin
      errors++;
      $display("FAIL rgb h=%0d v=%0d got %h expected %h", h, v, vout.rgb, er);
    end
    checks++;
    if (ot !== et) begin
      errors++;
      $display("FAIL timing h=%0d v=%0d got %h expected %h", h, v, ot, et);
    end
    checks++;
    if (busy !== exp_busy) begin
      errors++;
      $display("FAIL busy h=%0d v=%0d got %b expected %b", h, v, busy, exp_busy);
    end
    checks++;
    if (shot_ack !== exp_ack) begin
      errors++;
      $display("FAIL shot_ack h=%0d v=%0d got %b expected %b", h, v, shot_ack, exp_ack);
    end
  endtask

  // Frame start: a single vblank cycle; the position present now is what the frame draws.
  task automatic frame_begin(input bit do_shot, input bit exp_ack);
    model_cx = int'(xpos);
    model_cy = int'(ypos);
    pixel($urandom_range(0, 4095), $urandom_range(0, 4095), 1'b1, 1'b1, do_shot, exp_ack);
  endtask

  task automatic scan(input int x0, input int x1, input int y0, input int y1);
    int xa, xb, ya, yb;
    xa = (x0 < 0) ? 0 : x0;  xb = (x1 > 4095) ? 4095 : x1;
    ya = (y0 < 0) ? 0 : y0;  yb = (y1 > 4095) ? 4095 : y1;
    for (int y = ya; y <= yb; y++)
      for (int x = xa; x <= xb; x++)
        pixel(x, y, ($urandom_range(0, 15) == 0), 1'b0, 1'b0, 1'b0);
  endtask

  task automatic check_reset_outputs(input string tag);
    logic [41:0] obs;
    obs = {vout.hcount, vout.vcount, vout.hsync, vout.vsync, vout.hblnk, vout.vblnk,
           vout.rgb, shot_ack, busy};
    checks++;
    if (obs !== 42'd0) begin
      errors++;
      $display("FAIL %s outputs got %h expected 0", tag, obs);
    end
  endtask

  // One reset clock with busy, non-zero inputs.
  task automatic reset_cycle(input string tag);
    rst = 1'b1;
    vin.hcount = 12'($urandom_range(1, 4095));
    vin.vcount = 12'($urandom_range(1, 4095));
    vin.hsync = 1'b1; vin.vsync = 1'b1; vin.hblnk = 1'b0; vin.vblnk = 1'b0;
    vin.rgb = 12'hABC;
    shot = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    shot = 1'b0;
    check_reset_outputs(tag);
    exp_busy = 0;
    exp_flash = 0;
  endtask

  task automatic test_reset;
    xpos = 12'd0; ypos = 12'd0;
    reset_cycle("reset");
    // Immediate pixel after reset: drawn around (0,0) in idle colour.
    scan(0, 3, 0, 3);
  endtask

  task automatic test_basic;
    xpos = 12'd100; ypos = 12'd100;
    exp_flash = 0; exp_busy = 0;
    frame_begin(1'b0, 1'b0);
    scan(90, 110, 90, 110);
  endtask

  task automatic test_clip;
    xpos = 12'd3; ypos = 12'd3;
    frame_begin(1'b0, 1'b0);
    scan(0, 14, 0, 14);
    scan(4085, 4095, 0, 6);
    scan(0, 6, 4085, 4095);
  endtask

  task automatic test_midframe;
    xpos = 12'd100; ypos = 12'd100;
    frame_begin(1'b0, 1'b0);
    scan(95, 105, 95, 105);
    pixel(100, 300, 1'b0, 1'b0, 1'b0, 1'b0);
    xpos = 12'd200;
    scan(95, 105, 95, 105);
    scan(195, 205, 95, 105);
    frame_begin(1'b0, 1'b0);
    scan(195, 205, 95, 105);
    scan(95, 105, 95, 105);
  endtask

  task automatic test_random;
    for (int f = 0; f < 6; f++) begin
      xpos = 12'($urandom_range(0, 4095));
      ypos = 12'($urandom_range(0, 4095));
      frame_begin(1'b0, 1'b0);
      scan(int'(xpos) - 9, int'(xpos) + 9, int'(ypos) - 9, int'(ypos) + 9);
    end
  endtask

  // Frame f after the shot: flash for frames 0..7, cooldown 8..11, idle from 12.
  task automatic run_flash(input bit shot_at_start, input int rst_frame);
    xpos = 12'd100; ypos = 12'd100;
    for (int f = 0; f <= 13; f++) begin
      if (f == 0 && !shot_at_start) begin
        exp_flash = 0; exp_busy = 0;
        frame_begin(1'b0, 1'b0);
        exp_flash = 1; exp_busy = 1;
        pixel(0, 0, 1'b1, 1'b0, 1'b1, 1'b1);
      end else begin
        exp_flash = (f < 8);
        exp_busy  = (f < 12);
        frame_begin(f == 0, f == 0);
      end
      if (f == 3) begin
        // A second shot during the flash is dropped.
        pixel(0, 0, 1'b1, 1'b0, 1'b1, 1'b0);
      end
      if (f == rst_frame) begin
        scan(95, 105, 95, 100);
        reset_cycle("reset_mid_flash");
        return;
      end
      scan(92, 108, 92, 108);
    end
  endtask

  task automatic test_flash;
    run_flash(1'b0, -1);
  endtask

  task automatic test_shot_on_frame;
    run_flash(1'b1, -1);
  endtask

  task automatic test_reset_mid_flash;
    run_flash(1'b1, 3);
    xpos = 12'd120; ypos = 12'd110;
    exp_flash = 0; exp_busy = 0;
    frame_begin(1'b0, 1'b0);
    scan(110, 130, 100, 120);
  endtask

  initial begin
    rst = 1'b1;
    shot = 1'b0;
    xpos = 12'd0; ypos = 12'd0;
    vin.hcount = 12'd0; vin.vcount = 12'd0; vin.hsync = 1'b0; vin.vsync = 1'b0;
    vin.hblnk = 1'b0; vin.vblnk = 1'b0; vin.rgb = 12'd0;
    #1;
    test_reset();
    test_basic();
    test_clip();
    test_midframe();
    test_random();
    test_flash();
    test_shot_on_frame();
    test_reset_mid_flash();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
